// File: rtl/lfsr_timer_pkg.sv
// Shared types for the programmable LFSR interval timer.
// FSM state encoding and the all-ones LFSR seed helper.
package lfsr_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    RUN  = 2'd2
  } state_e;

  // All-ones pattern of w bits, zero-extended to 16 bits.
  function automatic logic [15:0] lfsr_seed(input int unsigned w);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) s[i] = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/lfsr_timer_prog_step.sv
// One Fibonacci LFSR step: shift left, XOR of tapped bits into bit 0.
// Ports: cur (present state) -> nxt (next state), purely combinational.
module lfsr_step #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(8'b10001110)
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/lfsr_timer_prog.sv
// Runtime-programmable LFSR interval timer, periodic or one-shot.
// Ports: clk, rst (sync, active-low), start/stop requests,
// period_in/oneshot_in (sampled on start), pulseOut (1-cycle expiry),
// busy (SEEK/RUN), seeking (SEEK), cfgErr (start with period 0).
module lfsr_timer_prog
  import lfsr_timer_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'b10001110)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] period_in,
  input  logic             oneshot_in,
  output logic             pulseOut,
  output logic             busy,
  output logic             seeking,
  output logic             cfgErr
);

  localparam logic [WIDTH-1:0] SEED =
    WIDTH'(lfsr_seed(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             oneshot_q, oneshot_d;
  logic             pulse_q, pulse_d;
  logic             cfg_err_q, cfg_err_d;

  logic [WIDTH-1:0] shadow_nxt;
  logic [WIDTH-1:0] lfsr_nxt;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step_shadow (
    .cur (shadow_q),
    .nxt (shadow_nxt)
  );

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step_run (
    .cur (lfsr_q),
    .nxt (lfsr_nxt)
  );

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    term_d    = term_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    oneshot_d = oneshot_q;
    pulse_d   = 1'b0;
    cfg_err_d = 1'b0;

    if (stop) begin
      state_d = IDLE;
      lfsr_d  = SEED;
    end else if (start) begin
      // Restart drops any match in this cycle, so no pulse follows.
      lfsr_d = SEED;
      if (period_in == '0) begin
        cfg_err_d = 1'b1;
        state_d   = IDLE;
      end else begin
        oneshot_d = oneshot_in;
        shadow_d  = SEED;
        cnt_d     = period_in - WIDTH'(1);
        state_d   = SEEK;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        SEEK: begin
          if (cnt_q != '0) begin
            shadow_d = shadow_nxt;
            cnt_d    = cnt_q - WIDTH'(1);
          end else begin
            term_d  = shadow_q;
            lfsr_d  = SEED;
            state_d = RUN;
          end
        end
        RUN: begin
          if (lfsr_q == term_q) begin
            lfsr_d  = SEED;
            pulse_d = 1'b1;
            if (oneshot_q) state_d = IDLE;
          end else begin
            lfsr_d = lfsr_nxt;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      term_q    <= SEED;
      shadow_q  <= SEED;
      cnt_q     <= '0;
      oneshot_q <= 1'b0;
      pulse_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      term_q    <= term_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      oneshot_q <= oneshot_d;
      pulse_q   <= pulse_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pulseOut = pulse_q;
  assign cfgErr   = cfg_err_q;
  assign busy     = (state_q != IDLE);
  assign seeking  = (state_q == SEEK);

endmodule
